fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  out  N  byte address of request.
REQ-008 SHALL have port imem_rsp_valid  in  1  in-order response valid; responses are always accepted.
REQ-009 SHALL have port imem_rsp_data  in  N  instruction word.
REQ-010 SHALL have port flush  in  1  branch redirect, from IF_Flush.
REQ-011 SHALL have port flush_pc  in  N  redirect target.
REQ-012 SHALL have port deq_ready  in  1  IF stage consumes (the inverse of freeze).
REQ-013 SHALL have port deq_valid  out  1  queue head valid.
REQ-014 SHALL have port deq_inst  out  N  head instruction.
REQ-015 SHALL have port deq_pc  out  N  head instruction address.
REQ-016 SHALL have port occupancy  out  $clog2(DEPTH)+1  valid entries.

Function
REQ-017 SHALL issue a request (imem_req_valid=1) in state FETCH when occupancy + outstanding < DEPTH; the transfer occurs when valid&ready.
REQ-018 SHALL advance fetch_pc by 4 on each transfer; fetch_pc wraps modulo 2^N.
REQ-019 SHALL hold imem_req_addr stable while valid is high and ready is low.
REQ-020 SHALL store each non-stale response with its request PC at the tail, one cycle after imem_rsp_valid.
REQ-021 SHALL dequeue the head when deq_valid&deq_ready; deq_inst and deq_pc are registered head outputs.
REQ-022 SHALL perform enqueue and dequeue together in the same cycle, with occupancy unchanged, including when full.
REQ-023 SHALL never overflow, guaranteed by the outstanding-credit rule of REQ-017; a response arriving with no free entry is a protocol error and is asserted in simulation only.
REQ-024 SHALL, on flush: empty the queue in the same cycle (deq_valid=0 next cycle), set fetch_pc=flush_pc, drop_cnt=outstanding, and ignore any same-cycle dequeue or enqueue.
REQ-025 SHALL have FSM states FETCH and DRAIN. FETCH->DRAIN on flush with outstanding>0. DRAIN->FETCH when the last stale response arrives (drop_cnt==1 && rsp_valid) and no new flush occurs. Flush with outstanding==0 stays in FETCH and issues from flush_pc in the next cycle.
REQ-026 SHALL, in DRAIN, issue no requests and drop every response, decrementing drop_cnt; a flush in DRAIN reloads fetch_pc only.
REQ-027 SHALL, on a request whose transfer is in progress during a flush, count that request as outstanding (stale).
REQ-028 SHALL keep outstanding <= DEPTH, incremented on transfer and decremented on response; both together leave it unchanged.

Reset
REQ-029 SHALL, on reset: state=FETCH, fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, imem_req_valid=0, deq_valid=0, deq_inst=0, deq_pc=0, occupancy=0.
REQ-030 SHALL start issuing requests on the first clock edge after rst deasserts.
REQ-031 SHALL, when rst asserts mid-operation, discard all state immediately; responses to earlier requests are the memory's responsibility (the memory is reset too).

Configuration
REQ-032 SHALL, with FETCH_QUEUE_STATS_EN defined, add outputs stat_fetched (32b, responses enqueued) and stat_dropped (32b, stale responses dropped), both saturating and cleared on reset.
REQ-033 SHALL, without FETCH_QUEUE_STATS_EN, omit those ports and counters entirely.

Structure
REQ-034 SHALL take N and a new fq_state_t enum (FETCH, DRAIN) from package defines.
REQ-035 SHALL instantiate one sub-module, fq_fifo (circular buffer of {pc,inst}, with push, pop and clear), while the FSM and credit logic stay in fetch_queue.

Verification
REQ-036 SHALL cover reset release with RESET_PC=0x100 and ready=1, zero-latency response: requests to 0x100, 0x104, 0x108, 0x10C, with deq_pc sequence 0x100 onward.
REQ-037 SHALL cover deq_ready=0 for 10 cycles: occupancy saturates at 4, no fifth request, and nothing is lost when deq_ready returns.
REQ-038 SHALL cover flush to 0x400 with 2 outstanding: two responses are dropped, deq_valid=0 until the 0x400 instruction arrives, and stat_dropped=2.
REQ-039 SHALL cover a second flush to 0x800 during DRAIN: only 0x800-stream instructions are delivered afterwards.
REQ-040 SHALL cover imem_req_ready held low for 5 cycles: addr stable, exactly one transfer.
REQ-041 SHALL cover rst asserted while full: all outputs go to reset values asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared width, FSM state type and queue entry layout for the fetch queue.
package fetch_queue_pkg;

    localparam int N = 32;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: circular buffer of {pc,inst} with push, pop and single-cycle clear.
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  fq_entry_t              data_i,
    output logic                   valid_o,
    output fq_entry_t              data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;

    // Storage is reset too so the head outputs read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign valid_o = cnt_q != '0;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction prefetch queue with flush/drain of stale responses.
// Optional statistics counters are enabled by defining FETCH_QUEUE_STATS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int           DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [N-1:0]           imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [N-1:0]           imem_rsp_data,
    input  logic                   flush,
    input  logic [N-1:0]           flush_pc,
    input  logic                   deq_ready,
    output logic                   deq_valid,
    output logic [N-1:0]           deq_inst,
    output logic [N-1:0]           deq_pc,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_dropped
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t     state_q, state_d;
    logic [N-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d;
    logic          started_q;
    logic          xfer, push, pop;
    fq_entry_t     head;

    assign imem_req_valid = started_q && state_q == FETCH &&
                            ((CW+1)'(occupancy) + (CW+1)'(out_q) < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign xfer           = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && state_q == FETCH && !flush;
    assign pop            = deq_valid && deq_ready && !flush;

    // A transfer in the flush cycle is already stale, so it lands in drop_cnt via out_d.
    always_comb begin
        out_d      = out_q + CW'(xfer) - CW'(imem_rsp_valid);
        fetch_pc_d = flush ? flush_pc : xfer ? fetch_pc_q + N'(4) : fetch_pc_q;
        rsp_pc_d   = flush ? flush_pc : push ? rsp_pc_q + N'(4) : rsp_pc_q;
        drop_d     = flush ? out_d :
                     (state_q == DRAIN && imem_rsp_valid) ? drop_q - CW'(1) : drop_q;
        state_d    = flush ? (out_d != '0 ? DRAIN : FETCH) :
                     (state_q == DRAIN && drop_q == CW'(1) && imem_rsp_valid) ? FETCH : state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            started_q  <= 1'b1;
        end
    end

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ('{pc: rsp_pc_q, inst: imem_rsp_data}),
        .valid_o (deq_valid),
        .data_o  (head),
        .count_o (occupancy)
    );

    assign deq_pc   = head.pc;
    assign deq_inst = head.inst;

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && occupancy == CW'(DEPTH)));

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] fetched_q, dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (push && ~&fetched_q) fetched_q <= fetched_q + 32'd1;
            if (imem_rsp_valid && !push && ~&dropped_q) dropped_q <= dropped_q + 32'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_dropped = dropped_q;
`endif

endmodule
